// File: rtl/rvs192_cache_pkg.sv
// Shared cache definitions: default word/tag widths and the write-buffer drain FSM states.
package rvs192_cache_pkg;

  localparam int DEFAULT_DATA_LENGTH = 32;
  localparam int DEFAULT_TAG_LENGTH  = 30;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CAPTURE,
    REQ
  } drain_state_e;

endpackage

// File: rtl/wb_drain_timer.sv
// Ack-wait timer for the drain controller: counts enabled cycles and flags the cycle in which
// the count reaches TIMEOUT.
module wb_drain_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  // Saturate at TIMEOUT so a long stall cannot wrap and re-fire the expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/wb_drain_ctrl.sv
// Write-buffer drain controller: pops one {tag,data} entry at a time from the write buffer and
// writes it to memory, with flush handling and a sticky ack-timeout error.
module wb_drain_ctrl
  import rvs192_cache_pkg::*;
#(
  parameter int DATA_LENGTH = DEFAULT_DATA_LENGTH,
  parameter int TAG_LENGTH  = DEFAULT_TAG_LENGTH,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_LENGTH+TAG_LENGTH-1:0] wb_data,
  input  logic                              wb_empty,
  output logic                              wb_load,
  input  logic                              rd_pending,
  input  logic                              flush_req,
  output logic                              flush_done,
  output logic                              drain_lock,
  output logic                              mem_req,
  output logic [TAG_LENGTH+1:0]             mem_addr,
  output logic [DATA_LENGTH-1:0]            mem_wdata,
  input  logic                              mem_ack,
  output logic                              bus_err,
  input  logic                              err_clr,
  output logic                              busy
);

  drain_state_e state, state_nxt;

  logic [TAG_LENGTH-1:0]  tag_q;
  logic [DATA_LENGTH-1:0] data_q;
  logic                   flush_pend;
  logic                   start;
  logic                   timer_expired;
  logic                   timeout_hit;

  // A pending flush overrides a read miss so the buffer can be emptied.
  assign start = !wb_empty && (!rd_pending || flush_pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wb_load    = 1'b0;
    mem_req    = 1'b0;
    drain_lock = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        drain_lock = 1'b1;
        state_nxt  = CAPTURE;
      end
      CAPTURE: begin
        // Only the drain pops the buffer, so empty here means the entry vanished; never pop it.
        drain_lock = 1'b1;
        if (!wb_empty) begin
          wb_load   = 1'b1;
          state_nxt = REQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q  <= '0;
      data_q <= '0;
    end else if (wb_load) begin
      tag_q  <= wb_data[DATA_LENGTH+TAG_LENGTH-1:DATA_LENGTH];
      data_q <= wb_data[DATA_LENGTH-1:0];
    end
  end

  assign mem_addr  = {tag_q, 2'b00};
  assign mem_wdata = data_q;

  wb_drain_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == CAPTURE),
    .enable  (state == REQ),
    .expired (timer_expired)
  );

  // An ack landing on the expiry cycle completes cleanly instead of raising an error.
  assign timeout_hit = timer_expired && !mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err <= 1'b0;
    end else if (timeout_hit) begin
      bus_err <= 1'b1;
    end else if (err_clr) begin
      bus_err <= 1'b0;
    end
  end

  assign flush_done = (state == IDLE) && flush_pend && wb_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend <= 1'b0;
    end else if (flush_req) begin
      flush_pend <= 1'b1;
    end else if (flush_done) begin
      flush_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_drain_ctrl.sv
// Scoreboard bench for wb_drain_ctrl: a queue-based write buffer model, an ack responder and a
// monitor that checks every memory request against hand-computed expected transactions.
module tb_wb_drain_ctrl;

  localparam int DW = 32;
  localparam int TW = 30;
  localparam int TO = 8;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } entry_t;

  typedef struct {
    logic [TW+1:0] addr;
    logic [DW-1:0] data;
    int            gap;
  } txn_t;

  logic             clk;
  logic             rst_n;
  logic [DW+TW-1:0] wb_data;
  logic             wb_empty;
  logic             wb_load;
  logic             rd_pending;
  logic             flush_req;
  logic             flush_done;
  logic             drain_lock;
  logic             mem_req;
  logic [TW+1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_ack;
  logic             bus_err;
  logic             err_clr;
  logic             busy;

  entry_t push_q[$];
  entry_t wb_q[$];
  txn_t   exp_q[$];

  int   vectors = 0;
  int   miscompares = 0;
  int   load_cnt = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   ack_wait = 0;
  int   req_cycles = 0;
  logic ack_enable = 1'b1;
  logic pop_pending = 1'b0;

  logic          prev_req = 1'b0;
  logic          prev_ack = 1'b0;
  logic [TW+1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  int            last_rise = 0;
  txn_t          cur;

  wb_drain_ctrl #(
    .DATA_LENGTH (DW),
    .TAG_LENGTH  (TW),
    .TIMEOUT     (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_data    (wb_data),
    .wb_empty   (wb_empty),
    .wb_load    (wb_load),
    .rd_pending (rd_pending),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .drain_lock (drain_lock),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .bus_err    (bus_err),
    .err_clr    (err_clr),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [TW-1:0] tag, input logic [DW-1:0] data,
                               input logic [TW+1:0] exp_addr, input int gap);
    entry_t e;
    txn_t   t;
    e.tag  = tag;
    e.data = data;
    t.addr = exp_addr;
    t.data = data;
    t.gap  = gap;
    push_q.push_back(e);
    exp_q.push_back(t);
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n = 0;
    while (!(push_q.size() == 0 && wb_empty && !busy && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_drained"}, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_req(input string name, input int budget);
    int n = 0;
    while (!mem_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_req_seen"}, 64'(mem_req), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_mem_req"}, mem_req, 0);
    checkOutput({tag, "_wb_load"}, wb_load, 0);
    checkOutput({tag, "_flush_done"}, flush_done, 0);
    checkOutput({tag, "_bus_err"}, bus_err, 0);
    checkOutput({tag, "_drain_lock"}, drain_lock, 0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // Write buffer model: pops on a sampled wb_load, presents the head just after the clock edge.
  initial begin
    wb_empty = 1'b1;
    wb_data  = '0;
    forever begin
      @(negedge clk);
      pop_pending = wb_load;
      @(posedge clk);
      #1;
      if (pop_pending && wb_q.size() > 0) wb_q.delete(0);
      while (push_q.size() > 0) wb_q.push_back(push_q.pop_front());
      if (wb_q.size() > 0) begin
        wb_empty = 1'b0;
        wb_data  = {wb_q[0].tag, wb_q[0].data};
      end else begin
        wb_empty = 1'b1;
      end
    end
  end

  // Memory responder: single-cycle ack after ack_wait REQ cycles when enabled.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack    = 1'b0;
        req_cycles = 0;
      end else if (mem_req) begin
        if (ack_enable && req_cycles >= ack_wait) mem_ack = 1'b1;
        req_cycles++;
      end else begin
        req_cycles = 0;
      end
    end
  end

  // Monitor: scoreboard pops on each new request, plus per-cycle protocol checks.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_req = 1'b0;
        prev_ack = 1'b0;
      end else begin
        if (prev_ack) checkOutput("busy_after_ack", busy, 0);
        if (wb_load) begin
          load_cnt++;
          checkOutput("load_nonempty", wb_empty, 0);
          checkOutput("lock_in_capture", drain_lock, 1);
        end
        if (flush_done) begin
          done_cnt++;
          checkOutput("done_when_empty", wb_empty, 1);
          checkOutput("done_when_idle", busy, 0);
        end
        if (mem_req && !prev_req) begin
          checkOutput("lock_off_in_req", drain_lock, 0);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_req: got mem_req=1, expected no request (scoreboard empty)");
          end else begin
            cur = exp_q.pop_front();
            checkOutput("mem_addr", mem_addr, cur.addr);
            checkOutput("mem_wdata", mem_wdata, cur.data);
            if (cur.gap != 0) checkOutput("req_spacing", 64'(cyc - last_rise), 64'(cur.gap));
          end
          last_rise = cyc;
        end else if (mem_req) begin
          checkOutput("addr_stable", mem_addr, prev_addr);
          checkOutput("wdata_stable", mem_wdata, prev_data);
        end
        prev_req  = mem_req;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
        prev_data = mem_wdata;
      end
    end
  end

  initial begin
    int base;
    int dbase;
    rst_n      = 1'b0;
    rd_pending = 1'b0;
    flush_req  = 1'b0;
    err_clr    = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single store");
    ack_wait = 3;
    base = load_cnt;
    applyStimulus(30'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0040, 0);
    wait_drained("single", 40);
    checkOutput("single_loads", 64'(load_cnt - base), 1);
    checkOutput("single_busy", busy, 0);

    $display("[TB] three queued entries, immediate ack");
    ack_wait = 0;
    base = load_cnt;
    applyStimulus(30'h0000_0100, 32'h1111_1111, 32'h0000_0400, 0);
    applyStimulus(30'h0000_0101, 32'h2222_2222, 32'h0000_0404, 4);
    applyStimulus(30'h3FFF_FFFF, 32'h3333_3333, 32'hFFFF_FFFC, 4);
    wait_drained("burst", 60);
    checkOutput("burst_loads", 64'(load_cnt - base), 3);

    $display("[TB] read pending blocks drain, flush overrides");
    rd_pending = 1'b1;
    base = load_cnt;
    applyStimulus(30'h0000_2000, 32'hA5A5_A5A5, 32'h0000_8000, 0);
    applyStimulus(30'h0000_2001, 32'h5A5A_5A5A, 32'h0000_8004, 4);
    repeat (10) @(negedge clk);
    checkOutput("rdpend_busy", busy, 0);
    checkOutput("rdpend_req", mem_req, 0);
    checkOutput("rdpend_loads", 64'(load_cnt - base), 0);
    dbase = done_cnt;
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    wait_drained("flush", 60);
    repeat (4) @(negedge clk);
    checkOutput("flush_done_count", 64'(done_cnt - dbase), 1);
    checkOutput("flush_loads", 64'(load_cnt - base), 2);
    rd_pending = 1'b0;

    $display("[TB] ack on the timeout cycle");
    ack_wait = TO - 1;
    applyStimulus(30'h0000_0ABC, 32'hCAFE_0001, 32'h0000_2AF0, 0);
    wait_drained("ack_at_timeout", 40);
    checkOutput("ack_at_timeout_err", bus_err, 0);

    $display("[TB] timeout with no ack");
    ack_enable = 1'b0;
    ack_wait   = 0;
    applyStimulus(30'h0123_4567, 32'h0BAD_F00D, 32'h048D_159C, 0);
    wait_req("timeout", 40);
    repeat (TO - 1) @(negedge clk);
    checkOutput("err_before_timeout", bus_err, 0);
    @(negedge clk);
    checkOutput("err_at_timeout", bus_err, 1);
    checkOutput("req_held_on_err", mem_req, 1);
    ack_enable = 1'b1;
    wait_drained("timeout", 40);
    checkOutput("err_sticky", bus_err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("err_cleared", bus_err, 0);

    $display("[TB] reset during REQ");
    ack_enable = 1'b0;
    applyStimulus(30'h00F0_0F00, 32'h7777_8888, 32'h03C0_3C00, 0);
    wait_req("rst_mid", 40);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    ack_enable = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_req", mem_req, 0);
    checkOutput("post_rst_empty", wb_empty, 1);

    checkOutput("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
